// File: rtl/mem_slot_arbiter.sv
// Time-division arbiter for the shared frame-buffer/glyph-ROM port: two VGA slots and six CPU slots per 8-cycle frame.
// Optional write protection below ROM_LIMIT is enabled by defining ARB_WPROT_EN.
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif

module mem_slot_arbiter #(
    parameter int unsigned     AW        = 16,
    parameter int unsigned     DW        = `DATAWIDTH,
    parameter logic [AW-1:0]   ROM_LIMIT = AW'(16'h0800)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [2:0]    acnt,
    input  logic [AW-1:0] vga_addr,
    output logic [DW-1:0] glyph_num,
    output logic [DW-1:0] glyph_pixels,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          wprot_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

`ifdef ARB_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   vga_slot_c;
    logic   wr_blocked_c;
    logic   prot_hit_c;

    assign vga_slot_c   = (acnt == 3'd1) || (acnt == 3'd2);
    assign wr_blocked_c = WPROT && (cpu_addr < ROM_LIMIT);

    // Next state and shared-port drive; VGA slots always own the address bus.
    always_comb begin
        state_nxt  = state;
        mem_addr   = cpu_addr;
        mem_we     = 1'b0;
        mem_wdata  = cpu_wdata;
        prot_hit_c = 1'b0;
        if (vga_slot_c) begin
            mem_addr = vga_addr;
        end
        case (state)
            IDLE: begin
                if (!vga_slot_c && cpu_req) begin
                    if (cpu_we) begin
                        mem_we     = !wr_blocked_c;
                        prot_hit_c = wr_blocked_c;
                        state_nxt  = ACK;
                    end else begin
                        state_nxt  = RD_WAIT;
                    end
                end
            end
            RD_WAIT: state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Slot counter, FSM state and data capture for both clients.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            acnt         <= 3'd0;
            glyph_num    <= '0;
            glyph_pixels <= '0;
            cpu_rdata    <= '0;
            cpu_ack      <= 1'b0;
            wprot_err    <= 1'b0;
        end else begin
            state   <= state_nxt;
            acnt    <= acnt + 3'd1;
            cpu_ack <= (state_nxt == ACK);
            // Memory data lags the address by one cycle, so each capture is one slot late.
            if (acnt == 3'd2) begin
                glyph_num <= mem_rdata;
            end
            if (acnt == 3'd3) begin
                glyph_pixels <= mem_rdata;
            end
            if (state == RD_WAIT) begin
                cpu_rdata <= mem_rdata;
            end
            if (prot_hit_c) begin
                wprot_err <= 1'b1;
            end
        end
    end

endmodule
